// File: rtl/eight_bit_adder_pkg.sv
// Shared definitions for the ripple-carry adder building block.
package eight_bit_adder_pkg;

  // Native width of the building block; wider adders cascade instances.
  localparam int ADDER_WIDTH = 8;

  // Operand vector at the native width.
  typedef logic [ADDER_WIDTH-1:0] operand_t;

endpackage

// File: rtl/eight_bit_adder_full_adder.sv
// One-bit full adder cell; the unit of the ripple-carry chain.
module full_adder
  import eight_bit_adder_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and majority carry, purely combinational.
  always_comb begin
    s    = x ^ y ^ cin;
    cout = (x & y) | (x & cin) | (y & cin);
  end

endmodule

// File: rtl/eight_bit_adder.sv
// Registered ripple-carry adder: WIDTH full_adder cells chained carry-out to
// carry-in, with the sum and carry-out captured on the clock.
module eight_bit_adder
  import eight_bit_adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid
);

  // ---- stage p0: combinational ripple chain ----
  // carry_p0[i] is the carry into bit i; carry_p0[WIDTH] is the carry-out.
  logic [WIDTH:0]   carry_p0;
  logic [WIDTH-1:0] sum_p0;

  assign carry_p0[0] = c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .x    (a[i]),
      .y    (b[i]),
      .cin  (carry_p0[i]),
      .s    (sum_p0[i]),
      .cout (carry_p0[i+1])
    );
  end

  // ---- stage p1: output register ----
  logic [WIDTH-1:0] sum_p1;
  logic             carry_p1;
  logic             vld_p1;

  // Capture a fresh result on valid input; otherwise hold data and drop valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_p1   <= '0;
      carry_p1 <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        sum_p1   <= sum_p0;
        carry_p1 <= carry_p0[WIDTH];
      end
    end
  end

  assign sum       = sum_p1;
  assign carry     = carry_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_eight_bit_adder.sv
// Bench for eight_bit_adder: directed corner cases followed by random traffic
// compared against an arithmetic reference model.
module tb_eight_bit_adder;
  import eight_bit_adder_pkg::*;

  logic     clk;
  logic     rst_n;
  operand_t a;
  operand_t b;
  logic     c;
  logic     in_valid;
  operand_t sum;
  logic     carry;
  logic     out_valid;

  int compared;
  int mismatched;

  // Reference model state: what the outputs should show after the last edge.
  operand_t m_sum;
  logic     m_carry;
  logic     m_vld;

  eight_bit_adder #(.WIDTH(ADDER_WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .c         (c),
    .in_valid  (in_valid),
    .sum       (sum),
    .carry     (carry),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs away from the edge, clock it in, then update
  // the model from the arithmetic definition of the adder.
  task automatic apply(input logic r, input operand_t ta, input operand_t tb,
                       input logic tc, input logic tv);
    logic [ADDER_WIDTH:0] total;
    @(negedge clk);
    rst_n    = r;
    a        = ta;
    b        = tb;
    c        = tc;
    in_valid = tv;
    @(posedge clk);
    #1;
    total = ADDER_WIDTH'(0) + {1'b0, ta} + {1'b0, tb} + (ADDER_WIDTH + 1)'(tc);
    if (!r) begin
      m_sum   = '0;
      m_carry = 1'b0;
      m_vld   = 1'b0;
    end else if (tv) begin
      m_sum   = total[ADDER_WIDTH-1:0];
      m_carry = total[ADDER_WIDTH];
      m_vld   = 1'b1;
    end else begin
      m_vld   = 1'b0;
    end
  endtask

  task automatic check(input string tag, input operand_t es, input logic ec,
                       input logic ev);
    compared++;
    assert ({sum, carry, out_valid} === {es, ec, ev})
    else begin
      mismatched++;
      $error("FAIL %s: observed sum=%h carry=%b out_valid=%b, expected sum=%h carry=%b out_valid=%b",
             tag, sum, carry, out_valid, es, ec, ev);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    m_sum      = '0;
    m_carry    = 1'b0;
    m_vld      = 1'b0;
    rst_n      = 1'b0;
    a          = '0;
    b          = '0;
    c          = 1'b0;
    in_valid   = 1'b0;

    // Reset held two cycles while valid all-ones operands are presented.
    apply(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1);
    check("reset_cycle1", 8'h00, 1'b0, 1'b0);
    apply(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1);
    check("reset_cycle2", 8'h00, 1'b0, 1'b0);

    // Directed arithmetic corners.
    apply(1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
    check("zero", 8'h00, 1'b0, 1'b1);
    apply(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1);
    check("ff_ff_c0", 8'hFE, 1'b1, 1'b1);
    apply(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1);
    check("ff_ff_c1", 8'hFF, 1'b1, 1'b1);
    apply(1'b1, 8'hAA, 8'hFF, 1'b1, 1'b1);
    check("aa_ff_c1", 8'hAA, 1'b1, 1'b1);
    apply(1'b1, 8'h01, 8'hFF, 1'b0, 1'b1);
    check("long_ripple", 8'h00, 1'b1, 1'b1);
    apply(1'b1, 8'h00, 8'h00, 1'b1, 1'b1);
    check("carry_in_only", 8'h01, 1'b0, 1'b1);

    // Back-to-back results, then hold when valid drops.
    apply(1'b1, 8'h0F, 8'h01, 1'b0, 1'b1);
    check("b2b_first", 8'h10, 1'b0, 1'b1);
    apply(1'b1, 8'h80, 8'h80, 1'b0, 1'b1);
    check("b2b_second", 8'h00, 1'b1, 1'b1);
    apply(1'b1, 8'h33, 8'h44, 1'b1, 1'b0);
    check("hold_1", 8'h00, 1'b1, 1'b0);
    apply(1'b1, 8'h55, 8'h66, 1'b0, 1'b0);
    check("hold_2", 8'h00, 1'b1, 1'b0);

    // Reset arriving with a valid operand discards that result.
    apply(1'b1, 8'h12, 8'h34, 1'b0, 1'b1);
    check("pre_reset", 8'h46, 1'b0, 1'b1);
    apply(1'b0, 8'hF0, 8'h20, 1'b1, 1'b1);
    check("mid_reset", 8'h00, 1'b0, 1'b0);
    apply(1'b1, 8'hF0, 8'h20, 1'b1, 1'b0);
    check("post_reset_idle", 8'h00, 1'b0, 1'b0);

    // Random traffic against the reference model, with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      apply(($urandom_range(0, 49) != 0), operand_t'($urandom), operand_t'($urandom),
            1'($urandom), ($urandom_range(0, 3) != 0));
      check("random", m_sum, m_carry, m_vld);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
